pipe_word_assembler: RTL

PIPE_WORD_ASSEMBLER -- requirements
Module: pipe_word_assembler

---
 rtl/pipe_word_assembler_pkg.sv | 18 +
 rtl/pipe_word_assembler_if.sv | 25 ++
 rtl/pipe_word_assembler_idle_timer.sv | 36 +++
 rtl/pipe_word_assembler.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pipe_word_assembler_pkg.sv
// Shared types and constants for the pipe word assembler.
// Holds the FSM state enum, the header sync byte and the word-count helper.
package pipe_asm_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        EMIT    = 2'd2
    } state_e;

    localparam logic [7:0] SYNC_BYTE = 8'h5A;

    // Number of 16-bit data words needed to carry one assembled word.
    function automatic int calc_nw(input int bitwidth);
        return (bitwidth + 15) / 16;
    endfunction

endpackage

// File: rtl/pipe_word_assembler_if.sv
// Host-side and downstream-side signals of the pipe word assembler.
// The host (master) drives words in; the assembler (slave) produces strobes and status.
interface pipe_word_assembler_if #(
    parameter int BITWIDTH = 24,
    parameter int ADDR_W   = 8
);
    logic                in_valid;
    logic [15:0]         in_data;
    logic                in_ready;
    logic                out_set;
    logic [BITWIDTH-1:0] out_data;
    logic [ADDR_W-1:0]   out_addr;
    logic                busy;
    logic [7:0]          err_cnt;

    modport master (
        output in_valid, in_data,
        input  in_ready, out_set, out_data, out_addr, busy, err_cnt
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, out_set, out_data, out_addr, busy, err_cnt
    );
endinterface

// File: rtl/pipe_word_assembler_idle_timer.sv
// Counts idle cycles while a frame is being collected.
// expired is high during the TIMEOUT_CYC-th consecutive cycle with run set and no clear.
module idle_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired = run && (cnt_q == CW'(TIMEOUT_CYC - 1));

    // Next count: clear wins, otherwise count up while running until expiry.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run && !expired) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Idle counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/pipe_word_assembler.sv
// Assembles a header word plus ceil(BITWIDTH/16) 16-bit data words into one
// BITWIDTH-wide word with a channel address, and strobes it downstream.
// Optional feature: define PIPE_ASM_TIMEOUT_EN to abandon a frame after
// TIMEOUT_CYC cycles without an accepted word while collecting.
module pipe_word_assembler
    import pipe_asm_pkg::*;
#(
    parameter int BITWIDTH    = 24,
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_word_assembler_if.slave bus
);
    localparam int NW    = calc_nw(BITWIDTH);
    localparam int CNT_W = 3;

    state_e              state_q, state_d;
    logic [BITWIDTH-1:0] acc_q, acc_d;
    logic [BITWIDTH-1:0] accNext;
    logic [CNT_W-1:0]    wordCnt_q, wordCnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W-1:0]   outAddr_q, outAddr_d;
    logic [BITWIDTH-1:0] outData_q, outData_d;
    logic [7:0]          errCnt_q, errCnt_d;
    logic                accept;
    logic                isHeader;
    logic                errInc;
    logic                timeoutHit;

    assign bus.in_ready = (state_q != EMIT);
    assign accept       = bus.in_valid && bus.in_ready;
    assign isHeader     = (bus.in_data[7:0] == SYNC_BYTE);
    // Shifting in 16 bits and keeping only BITWIDTH bits drops the excess
    // upper bits of the first data word once the frame is complete.
    assign accNext      = BITWIDTH'({acc_q, bus.in_data});

`ifdef PIPE_ASM_TIMEOUT_EN
    idle_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) uIdleTimer (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept || (state_q != COLLECT)),
        .run    (state_q == COLLECT),
        .expired(timeoutHit)
    );
`else
    assign timeoutHit = 1'b0;
`endif

    // Next-state logic: header detection, word collection and result capture.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        wordCnt_d = wordCnt_q;
        addr_d    = addr_q;
        outData_d = outData_q;
        outAddr_d = outAddr_q;
        errInc    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (isHeader) begin
                        state_d   = COLLECT;
                        addr_d    = bus.in_data[8 +: ADDR_W];
                        wordCnt_d = '0;
                    end else begin
                        errInc = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (accept) begin
                    acc_d     = accNext;
                    wordCnt_d = wordCnt_q + CNT_W'(1);
                    if (wordCnt_q == CNT_W'(NW - 1)) begin
                        // Result registers load here so they are already
                        // valid during the EMIT strobe cycle.
                        state_d   = EMIT;
                        outData_d = accNext;
                        outAddr_d = addr_q;
                    end
                end else if (timeoutHit) begin
                    state_d = IDLE;
                    errInc  = 1'b1;
                end
            end
            EMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        errCnt_d = (errInc && (errCnt_q != 8'hFF)) ? errCnt_q + 8'd1 : errCnt_q;
    end

    // State and datapath registers; reset overrides any word accepted this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            wordCnt_q <= '0;
            addr_q    <= '0;
            outData_q <= '0;
            outAddr_q <= '0;
            errCnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            wordCnt_q <= wordCnt_d;
            addr_q    <= addr_d;
            outData_q <= outData_d;
            outAddr_q <= outAddr_d;
            errCnt_q  <= errCnt_d;
        end
    end

    assign bus.out_set  = (state_q == EMIT);
    assign bus.busy     = (state_q != IDLE);
    assign bus.out_data = outData_q;
    assign bus.out_addr = outAddr_q;
    assign bus.err_cnt  = errCnt_q;
endmodule
